// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: architectural PC plus CP0 SR/Cause/EPC and the interrupt-take FSM of the multicycle MIPS core.
// Define INT_SYNC_EN to place a 2-flop synchroniser in front of Cause.IP; default registers int_req_I once.
module cp0_exc_ctrl #(
   parameter logic [29:0] RESET_PC = 30'h0000_0C00,
   parameter int unsigned NUM_INT  = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:2]        npc_I,
   input  logic               PCWr_I,
   input  logic               instr_end_I,
   input  logic [NUM_INT-1:0] int_req_I,
   input  logic               eret_I,
   input  logic               c0_we_I,
   input  logic [4:0]         c0_sel_I,
   input  logic [31:0]        c0_wdata_I,
   output logic [31:2]        pc_O,
   output logic [31:2]        EPC_O,
   output logic [31:0]        c0_rdata_O,
   output logic               int_take_O,
   output logic               exl_O
);

   localparam logic [4:0] SEL_SR    = 5'd12;
   localparam logic [4:0] SEL_CAUSE = 5'd13;
   localparam logic [4:0] SEL_EPC   = 5'd14;

   typedef enum logic [1:0] {ST_RUN, ST_TAKE, ST_ISR} state_e;

   state_e             state_q, state_d;
   logic [29:0]        pc_q, pc_d;
   logic [29:0]        epc_q, epc_d;
   logic               ie_q, ie_d;
   logic               exl_q, exl_d;
   logic               take_q, take_d;
   logic [NUM_INT-1:0] im_q, im_d;
   logic [NUM_INT-1:0] ip_q, ip_d;
   logic [NUM_INT-1:0] req_s;
   logic               sr_wr, epc_wr, pending, take_now;
   logic [31:0]        sr_rd, cause_rd;
   logic               unused_wdata;

`ifdef INT_SYNC_EN
   logic [NUM_INT-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= int_req_I;
         sync2_q <= sync1_q;
      end
   end

   assign req_s = sync2_q;
`else
   assign req_s = int_req_I;
`endif

   assign sr_wr    = c0_we_I && (c0_sel_I == SEL_SR);
   assign epc_wr   = c0_we_I && (c0_sel_I == SEL_EPC);
   assign pending  = (|(ip_q & im_q)) & ie_q & ~exl_q;
   assign take_now = (state_q == ST_RUN) && instr_end_I && pending;

   // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      pc_d    = PCWr_I ? npc_I : pc_q;
      ip_d    = req_s;
      ie_d    = ie_q;
      im_d    = im_q;
      exl_d   = exl_q;
      epc_d   = epc_q;
      state_d = state_q;
      take_d  = 1'b0;

      if (sr_wr) begin
         ie_d  = c0_wdata_I[0];
         exl_d = c0_wdata_I[1];
         im_d  = c0_wdata_I[10 +: NUM_INT];
      end
      if (eret_I) exl_d = 1'b0;

      // An mtc0 to EPC in the take cycle beats the hardware capture.
      if (epc_wr)        epc_d = c0_wdata_I[31:2];
      else if (take_now) epc_d = PCWr_I ? npc_I : pc_q;

      unique case (state_q)
         ST_RUN: begin
            if (take_now) begin
               state_d = ST_TAKE;
               take_d  = 1'b1;
               exl_d   = 1'b1;
            end
         end
         ST_TAKE: state_d = ST_ISR;
         ST_ISR:  if (eret_I) state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         epc_q   <= '0;
         ie_q    <= 1'b0;
         exl_q   <= 1'b0;
         take_q  <= 1'b0;
         im_q    <= '0;
         ip_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         ie_q    <= ie_d;
         exl_q   <= exl_d;
         take_q  <= take_d;
         im_q    <= im_d;
         ip_q    <= ip_d;
      end
   end

   always_comb begin
      sr_rd                   = '0;
      sr_rd[0]                = ie_q;
      sr_rd[1]                = exl_q;
      sr_rd[10 +: NUM_INT]    = im_q;
      cause_rd                = '0;
      cause_rd[10 +: NUM_INT] = ip_q;
      unique case (c0_sel_I)
         SEL_SR:    c0_rdata_O = sr_rd;
         SEL_CAUSE: c0_rdata_O = cause_rd;
         SEL_EPC:   c0_rdata_O = {epc_q, 2'b00};
         default:   c0_rdata_O = '0;
      endcase
   end

   assign unused_wdata = ^{c0_wdata_I[31:10+NUM_INT], c0_wdata_I[9:2]};

   assign pc_O       = pc_q;
   assign EPC_O      = epc_q;
   assign int_take_O = take_q;
   assign exl_O      = exl_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed and randomized checks of cp0_exc_ctrl against a behavioural model of the CP0 rules.
// The model's interrupt latency follows INT_SYNC_EN the same way the design does.
module tb_cp0_exc_ctrl;

`ifdef INT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        clk, rst_n;
   logic [31:2] npc_I;
   logic        PCWr_I, instr_end_I, eret_I, c0_we_I;
   logic [5:0]  int_req_I;
   logic [4:0]  c0_sel_I;
   logic [31:0] c0_wdata_I;
   logic [31:2] pc_O, EPC_O;
   logic [31:0] c0_rdata_O;
   logic        int_take_O, exl_O;

   cp0_exc_ctrl #(.RESET_PC(30'h0000_0C00), .NUM_INT(6)) dut (
      .clk(clk), .rst_n(rst_n), .npc_I(npc_I), .PCWr_I(PCWr_I),
      .instr_end_I(instr_end_I), .int_req_I(int_req_I), .eret_I(eret_I),
      .c0_we_I(c0_we_I), .c0_sel_I(c0_sel_I), .c0_wdata_I(c0_wdata_I),
      .pc_O(pc_O), .EPC_O(EPC_O), .c0_rdata_O(c0_rdata_O),
      .int_take_O(int_take_O), .exl_O(exl_O)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // Behavioural model: architectural registers, request history, and two phase flags.
   logic [29:0] m_pc, m_epc;
   logic        m_ie, m_exl, m_take, m_handler;
   logic [5:0]  m_im;
   logic [5:0]  m_hist [LAT];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_pc = 30'h0000_0C00; m_epc = '0; m_ie = 0; m_exl = 0;
      m_take = 0; m_handler = 0; m_im = '0;
      for (int i = 0; i < LAT; i++) m_hist[i] = '0;
   endtask

   function automatic logic [31:0] m_rdata(input logic [4:0] sel);
      case (sel)
         5'd12:   return {16'h0, m_im, 8'h0, m_exl, m_ie};
         5'd13:   return {16'h0, m_hist[LAT-1], 10'h0};
         5'd14:   return {m_epc, 2'b00};
         default: return 32'h0;
      endcase
   endfunction

   task automatic compare_all();
      check("pc",    {2'b00, pc_O},  {2'b00, m_pc});
      check("epc",   {2'b00, EPC_O}, {2'b00, m_epc});
      check("exl",   {31'h0, exl_O}, {31'h0, m_exl});
      check("take",  {31'h0, int_take_O}, {31'h0, m_take});
      check("rdata", c0_rdata_O, m_rdata(c0_sel_I));
   endtask

   // One clock: derive the model's next state from pre-edge inputs, then compare after the edge.
   task automatic cycle();
      logic [29:0] n_pc, n_epc;
      logic        n_ie, n_exl, n_take, n_handler, pend, take;
      logic [5:0]  n_im;
      pend = ((m_hist[LAT-1] & m_im) != 6'h0) && m_ie && !m_exl;
      take = !m_take && !m_handler && instr_end_I && pend;
      n_pc = PCWr_I ? npc_I : m_pc;
      n_ie = m_ie; n_im = m_im; n_exl = m_exl; n_epc = m_epc;
      if (c0_we_I && c0_sel_I == 5'd12) begin
         n_ie = c0_wdata_I[0]; n_exl = c0_wdata_I[1]; n_im = c0_wdata_I[15:10];
      end
      if (eret_I) n_exl = 0;
      if (take)   n_exl = 1;
      if (c0_we_I && c0_sel_I == 5'd14) n_epc = c0_wdata_I[31:2];
      else if (take) n_epc = n_pc;
      n_take    = take;
      n_handler = m_take | (m_handler & !eret_I);
      @(posedge clk);
      if (!rst_n) m_reset();
      else begin
         for (int i = LAT - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = int_req_I;
         m_pc = n_pc; m_epc = n_epc; m_ie = n_ie; m_im = n_im; m_exl = n_exl;
         m_take = n_take; m_handler = n_handler;
      end
      #1 compare_all();
   endtask

   task automatic idle();
      PCWr_I = 0; instr_end_I = 0; eret_I = 0; c0_we_I = 0; c0_sel_I = 5'd12;
      c0_wdata_I = '0; npc_I = '0;
   endtask

   task automatic mtc0(input logic [4:0] sel, input logic [31:0] data);
      c0_we_I = 1; c0_sel_I = sel; c0_wdata_I = data;
      cycle();
      c0_we_I = 0;
   endtask

   initial begin
      rst_n = 0; int_req_I = '0;
      idle();
      m_reset();
      #11;
      check("rst_pc",   {2'b00, pc_O},  32'h0000_0C00);
      check("rst_epc",  {2'b00, EPC_O}, 32'h0);
      check("rst_take", {31'h0, int_take_O}, 32'h0);
      check("rst_sr",   c0_rdata_O, 32'h0);
      #1 rst_n = 1;

      // PC load and hold
      PCWr_I = 1; npc_I = 30'h100;
      cycle();
      check("pc_load", {2'b00, pc_O}, 32'h100);
      PCWr_I = 0; npc_I = 30'h3FF;
      cycle();
      check("pc_hold", {2'b00, pc_O}, 32'h100);

      // mtc0 / mfc0
      mtc0(5'd14, 32'h0000_1000);
      check("epc_wr", {2'b00, EPC_O}, 32'h400);
      c0_sel_I = 5'd14; #1 check("mfc0_epc", c0_rdata_O, 32'h0000_1000);
      c0_sel_I = 5'd7;  #1 check("mfc0_7", c0_rdata_O, 32'h0);

      // Masking: IM1 clear, then IE clear, then EXL set
      int_req_I = 6'b000010;
      mtc0(5'd12, 32'h0000_0401);
      repeat (LAT) cycle();
      c0_sel_I = 5'd13; #1 check("mfc0_cause", c0_rdata_O, 32'h0000_0800);
      instr_end_I = 1;
      repeat (10) begin cycle(); check("mask_im", {31'h0, int_take_O}, 32'h0); end
      instr_end_I = 0;
      mtc0(5'd12, 32'h0000_0800);
      instr_end_I = 1;
      repeat (10) begin cycle(); check("mask_ie", {31'h0, int_take_O}, 32'h0); end
      instr_end_I = 0;
      mtc0(5'd12, 32'h0000_0803);
      check("exl_set", {31'h0, exl_O}, 32'h1);
      instr_end_I = 1;
      repeat (10) begin cycle(); check("mask_exl", {31'h0, int_take_O}, 32'h0); end
      instr_end_I = 0;

      // Take
      int_req_I = 6'b000001;
      mtc0(5'd12, 32'h0000_0401);
      repeat (LAT) cycle();
      instr_end_I = 1; PCWr_I = 1; npc_I = 30'h204;
      cycle();
      check("take_epc", {2'b00, EPC_O}, 32'h204);
      check("take_exl", {31'h0, exl_O}, 32'h1);
      check("take_hi",  {31'h0, int_take_O}, 32'h1);
      idle();
      cycle();
      check("take_lo",  {31'h0, int_take_O}, 32'h0);

      // eret together with mtc0 SR, then the held request is taken again
      eret_I = 1; c0_we_I = 1; c0_sel_I = 5'd12; c0_wdata_I = 32'h0000_0403;
      cycle();
      idle();
      #1;
      check("eret_exl", {31'h0, exl_O}, 32'h0);
      check("eret_sr",  c0_rdata_O, 32'h0000_0401);
      instr_end_I = 1;
      cycle();
      check("retake", {31'h0, int_take_O}, 32'h1);

      // Asynchronous reset while in TAKE
      instr_end_I = 0;
      rst_n = 0;
      #1;
      check("arst_pc",   {2'b00, pc_O},  32'h0000_0C00);
      check("arst_epc",  {2'b00, EPC_O}, 32'h0);
      check("arst_take", {31'h0, int_take_O}, 32'h0);
      check("arst_exl",  {31'h0, exl_O}, 32'h0);
      m_reset();
      int_req_I = '0;
      cycle();
      #1 rst_n = 1;

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         PCWr_I      = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 15))
            0:       npc_I = 30'h3FFF_FFFF;
            1:       npc_I = 30'h0;
            default: npc_I = 30'($urandom);
         endcase
         instr_end_I = ($urandom_range(0, 2) == 0);
         eret_I      = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 7) == 0) int_req_I = 6'($urandom);
         c0_we_I     = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 4))
            0:       c0_sel_I = 5'd12;
            1:       c0_sel_I = 5'd13;
            2:       c0_sel_I = 5'd14;
            3:       c0_sel_I = 5'd7;
            default: c0_sel_I = 5'($urandom);
         endcase
         c0_wdata_I    = $urandom;
         c0_wdata_I[1] = ($urandom_range(0, 3) == 0);
         c0_wdata_I[0] = ($urandom_range(0, 3) != 0);
         #1 check("rd_comb", c0_rdata_O, m_rdata(c0_sel_I));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
